// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Provides the FSM state encoding, the default operand width and a helper
// that sizes the bit counter for a given operand width.
package serial_sub_pkg;

  // FSM state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default operand/result width, same as the parallel ripple adder.
  localparam int DEF_WIDTH = 4;

  // Counter width: must hold the values 0..w-1. A width below one bit
  // is not possible, so it is clamped to 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_sub4_if.sv
// Handshake and operand/result bundle for serial_sub4.
// Requester side (master) drives start, A, B and Bin. The subtractor side
// (slave) drives busy, done, D, Bout and V.
interface serial_sub4_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, V
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, V
  );

endinterface

// File: rtl/serial_sub4_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out in bout.
// Purely combinational.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow whenever the subtrahend side (b + bin) exceeds a.
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: D = A - B - Bin, processed LSB first, one bit per clock.
// Ports: clk, rst (synchronous, active high), bus (serial_sub4_if.slave):
//   start/A/B/Bin in; busy/done/D/Bout/V out.
// Latency: start accepted at edge t, then WIDTH SHIFT cycles, then a
// one-cycle DONE pulse. That gives one operation per WIDTH+2 cycles.
// A start seen while busy (SHIFT or DONE) is dropped. D/Bout/V hold until
// the next DONE.
// Optional: define SERIAL_SUB_OVF_EN to compute V as the signed overflow
// flag. Otherwise V is tied to 0.
module serial_sub4
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_sub4_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;
  logic             busy_o;
  logic             done_o;

  // Single bit-slice shared by every bit position.
  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // The new difference bit enters at the MSB. After WIDTH shifts, the
  // first bit computed has reached bit 0.
  assign res_shift = WIDTH'({fs_d, res_q} >> 1);
  assign last_bit  = (cnt_q == LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      SHIFT: busy_o = 1'b1;
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy = busy_o;
  assign bus.done = done_o;

`ifdef SERIAL_SUB_OVF_EN
  logic v_q, v_d;
`endif

  // ---------------- Datapath next state ----------------
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    d_d    = d_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    v_d    = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d = bus.A;
          b_sh_d = bus.B;
          br_d   = bus.Bin;
          res_d  = '0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = fs_bout;
        res_d  = res_shift;
        cnt_d  = cnt_q + 1'b1;
        // Publish the result on the last shift, so that D/Bout/V are
        // already valid while done is high.
        if (last_bit) begin
          d_d    = res_shift;
          bout_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          // br_q is the borrow into the MSB. fs_bout is the borrow out of it.
          v_d    = br_q ^ fs_bout;
`endif
        end
      end
      default: ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      v_q    <= 1'b0;
`endif
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      d_q    <= d_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      v_q    <= v_d;
`endif
    end
  end

  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.V    = v_q;
`else
  assign bus.V    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// Directed testbench for serial_sub4 (WIDTH=4).
// Hand-computed vectors, including the signed-overflow case when
// SERIAL_SUB_OVF_EN is defined. Also covers dropped starts, result hold
// and reset in the middle of an operation.
module tb_serial_sub4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  serial_sub4_if #(.WIDTH(4)) bus ();

  serial_sub4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge while the DUT is idle. It returns on the negedge
  // after the DONE cycle, with the DUT back in IDLE.
  // ev_ovf is the signed-overflow value for the operands. It is only
  // expected on V when the overflow feature is built in.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic bi, input logic [3:0] ed, input logic eb,
                        input logic ev_ovf, input logic [3:0] prev_d);
    logic ev;
`ifdef SERIAL_SUB_OVF_EN
    ev = ev_ovf;
`else
    ev = 1'b0;
`endif
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bi;
    @(negedge clk);
    // Change the operands after acceptance. This must have no effect.
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Bin   = ~bi;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      if (k < 4) check({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
      if (k == 1) bus.start = 1'b1;          // start during SHIFT: must be dropped
      if (k == 2) begin
        bus.start = 1'b0;
        check({tag, "_hold"}, {28'd0, bus.D}, {28'd0, prev_d});
      end
    end
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_D"},    {28'd0, bus.D},    {28'd0, ed});
    check({tag, "_Bout"}, {31'd0, bus.Bout}, {31'd0, eb});
    check({tag, "_V"},    {31'd0, bus.V},    {31'd0, ev});
    bus.start = 1'b1;                        // start during DONE: must be dropped
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_idle"},   {31'd0, bus.busy}, 32'd0);
    check({tag, "_pulse"},  {31'd0, bus.done}, 32'd0);
    check({tag, "_keepD"},  {28'd0, bus.D},    {28'd0, ed});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_D",    {28'd0, bus.D},    32'd0);
    check("rst_Bout", {31'd0, bus.Bout}, 32'd0);
    check("rst_V",    {31'd0, bus.V},    32'd0);
    rst = 1'b0;
    @(negedge clk);

    //      tag    A        B        Bin   D        Bout  Vovf  prevD
    run_op("t1", 4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    run_op("t2", 4'b1011, 4'b0111, 1'b1, 4'b0011, 1'b0, 1'b1, 4'b0000);
    run_op("t3", 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0011);
    run_op("t4", 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, 4'b0000);
    run_op("t5", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110);

    // Reset asserted during the 2nd SHIFT cycle.
    bus.start = 1'b1;
    bus.A     = 4'b0011;
    bus.B     = 4'b0101;
    bus.Bin   = 1'b0;
    @(negedge clk);              // first SHIFT cycle
    bus.start = 1'b0;
    @(negedge clk);              // second SHIFT cycle
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_done", {31'd0, bus.done}, 32'd0);
    check("mrst_D",    {28'd0, bus.D},    32'd0);
    check("mrst_Bout", {31'd0, bus.Bout}, 32'd0);
    check("mrst_V",    {31'd0, bus.V},    32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("mrst_nopulse", pulses, 0);
    check("mrst_idle", {31'd0, bus.busy}, 32'd0);

    // Normal operation after the reset.
    run_op("t7", 4'b1001, 4'b0010, 1'b0, 4'b0111, 1'b0, 1'b1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
